multi_delay_timer: RTL and testbench
====================================

Name: multi_delay_timer

Overview:
- N-channel programmable microsecond delay timer. It is the parametrised successor to the fixed single-channel delay.
- Each channel is started independently with a runtime delay value in microseconds and runs in one-shot or periodic mode.
- Each channel signals expiry with a single-cycle done pulse.
- Used by sequencing FSMs (ADC conversion waits, settle times, periodic sampling strobes) in place of per-site hard-coded delays.

Parameters:
- FREQ_MHZ, 50, clock frequency in MHz; clocks per microsecond; must be >= 1.
- N_CH, 4, number of independent channels; must be >= 1.
- DELAY_W, 16, width of each channel's delay value in microseconds; max delay 2^DELAY_W-1 us.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-high
- enable  input  1  global count enable; when low, all running channels freeze (no state change, no done)
- start  input  N_CH  per-channel start/retrigger request, sampled each clk edge
- abort  input  N_CH  per-channel stop request
- periodic  input  N_CH  mode, sampled with start: 0 = one-shot, 1 = periodic
- delay_us  input  N_CH*DELAY_W  per-channel delay; channel i occupies bits [i*DELAY_W +: DELAY_W]
- busy  output  N_CH  channel is in RUN
- done  output  N_CH  one-cycle expiry pulse per channel

Behaviour:
- Reset (async, rst=1): all channels IDLE; busy=0, done=0; all counters and latched values cleared. A reset mid-run drops the run with no done.
- Per channel: prescaler pre (width $clog2(FREQ_MHZ), minimum 1 bit), microsecond counter us (DELAY_W), latched target tgt, latched mode pmode.
- Per-channel FSM states are IDLE and RUN. busy = (state==RUN), registered.
- done is registered and is 0 in every cycle it is not explicitly pulsed.
- Priority per channel per edge: abort > start > terminal count > count.
- abort=1: state←IDLE, counters cleared, no done. This holds even if terminal count coincides, regardless of enable.
- start=1 with delay_us≠0 (from IDLE or RUN):
  - tgt←delay_us, pmode←periodic, pre←0, us←0, state←RUN.
  - Retrigger from RUN discards the current interval with no done.
  - Exception: if the current interval hits terminal count on that same edge, done pulses and the restart still applies.
- start=1 with delay_us=0: done pulses on the next edge, state←IDLE. Honoured regardless of enable.
- Counting, only in RUN with enable=1:
  - pre increments.
  - At pre==FREQ_MHZ-1, pre←0 and us increments.
- Terminal count is pre==FREQ_MHZ-1 and us==tgt-1 with enable=1. On terminal count, done←1 for one cycle.
  - One-shot: state←IDLE, busy←0 on the same edge.
  - Periodic: pre←0, us←0, tgt←current delay_us (rate may change live), stay RUN with no gap cycle. If the re-sampled delay_us is 0, state←IDLE after this done.
- Latency: start sampled at edge 0 → done high after edge tgt*FREQ_MHZ, assuming enable held high. Each enable-low cycle adds one cycle.
- Periodic done pulses are exactly tgt*FREQ_MHZ enabled cycles apart.
- enable low does not block start/abort/latching; it only freezes pre and us.
- Channels are fully independent; simultaneous events on different channels do not interact.
- No wrap-around: us never exceeds tgt-1.

Test Plan (FREQ_MHZ=4, N_CH=2, DELAY_W=8):
- One-shot: ch0 start, delay 3 → busy[0]=1 from edge 1. done[0] high for exactly one cycle after edge 12, busy[0]=0 on the same edge. ch1 untouched.
- Periodic: ch1 periodic, delay 2 → done[1] after edges 8, 16, 24. Switch delay_us to 1 before edge 24 → next done at edge 28. Set delay_us to 0 → channel goes IDLE after the following done.
- Abort and retrigger:
  - ch0 delay 5, abort at edge 7 → no done, busy[0]=0 after edge 7.
  - Restart delay 2 at edge 10, retrigger delay 3 at edge 14 → single done after edge 26.
  - Abort coincident with terminal count → no done.
- Zero delay and enable hold:
  - start with delay 0 → done pulse after edge 1, busy never set.
  - delay 2 with enable low for 3 cycles mid-run → done after edge 11 instead of 8.
- Reset mid-run: assert rst asynchronously (between edges) at cycle 5 of a delay-3 run → busy/done immediately 0, no done later. A new start after release times correctly from zero.
- Simultaneous: ch0 terminal count and start (delay 1) on the same edge → done pulse, then a second done 4 cycles later. ch1 running concurrently is unaffected.

Source files
------------

// File: rtl/multi_delay_timer.sv
// N-channel programmable microsecond delay timer with one-shot and periodic modes.
// Each channel derives a microsecond tick from a clock prescaler and pulses done once on expiry.
module multi_delay_timer #(
    parameter int FREQ_MHZ = 50,
    parameter int N_CH     = 4,
    parameter int DELAY_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [N_CH-1:0]         start,
    input  logic [N_CH-1:0]         abort,
    input  logic [N_CH-1:0]         periodic,
    input  logic [N_CH*DELAY_W-1:0] delay_us,
    output logic [N_CH-1:0]         busy,
    output logic [N_CH-1:0]         done
);

    localparam int PRE_W = (FREQ_MHZ > 1) ? $clog2(FREQ_MHZ) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(FREQ_MHZ - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
        state_t             state;
        logic [PRE_W-1:0]   pre;
        logic [DELAY_W-1:0] us;
        logic [DELAY_W-1:0] tgt;
        logic               pmode;
        logic               busy_q;
        logic               done_q;
        logic [DELAY_W-1:0] dly;
        logic               pre_wrap;
        logic               tc;

        assign dly      = delay_us[ch*DELAY_W +: DELAY_W];
        assign pre_wrap = (pre == PRE_LAST);
        // tgt is never zero while in RUN, so tgt-1 cannot underflow here.
        assign tc       = (state == RUN) && enable && pre_wrap && (us == tgt - DELAY_W'(1));

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state  <= IDLE;
                busy_q <= 1'b0;
                done_q <= 1'b0;
                pre    <= '0;
                us     <= '0;
                tgt    <= '0;
                pmode  <= 1'b0;
            end else begin
                done_q <= 1'b0;
                if (abort[ch]) begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    pre    <= '0;
                    us     <= '0;
                end else if (start[ch]) begin
                    pre <= '0;
                    us  <= '0;
                    if (dly != '0) begin
                        // An interval expiring on the restart edge still reports its done.
                        done_q <= tc;
                        tgt    <= dly;
                        pmode  <= periodic[ch];
                        state  <= RUN;
                        busy_q <= 1'b1;
                    end else begin
                        done_q <= 1'b1;
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end else if (state == RUN && enable) begin
                    if (tc) begin
                        done_q <= 1'b1;
                        pre    <= '0;
                        us     <= '0;
                        if (pmode && dly != '0) begin
                            tgt <= dly;
                        end else begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                        end
                    end else if (pre_wrap) begin
                        pre <= '0;
                        us  <= us + DELAY_W'(1);
                    end else begin
                        pre <= pre + PRE_W'(1);
                    end
                end
            end
        end

        assign busy[ch] = busy_q;
        assign done[ch] = done_q;
    end

endmodule

// File: tb/tb_multi_delay_timer.sv
// Scoreboard bench for multi_delay_timer: a remaining-cycles reference model predicts busy/done
// per edge, and a monitor compares every cycle; directed latency checks cover the key scenarios.
module tb_multi_delay_timer;

    localparam int FREQ_MHZ = 4;
    localparam int N_CH     = 2;
    localparam int DELAY_W  = 8;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    enable = 1'b0;
    logic [N_CH-1:0]         start = '0;
    logic [N_CH-1:0]         abort = '0;
    logic [N_CH-1:0]         periodic = '0;
    logic [N_CH*DELAY_W-1:0] delay_us = '0;
    logic [N_CH-1:0]         busy;
    logic [N_CH-1:0]         done;

    multi_delay_timer #(
        .FREQ_MHZ (FREQ_MHZ),
        .N_CH     (N_CH),
        .DELAY_W  (DELAY_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .start    (start),
        .abort    (abort),
        .periodic (periodic),
        .delay_us (delay_us),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N_CH-1:0] busy;
        logic [N_CH-1:0] done;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;
    bit   mon_on = 1'b1;

    // Reference model: each running channel holds the number of enabled edges left until expiry.
    bit   m_run[N_CH];
    int   m_rem[N_CH];
    bit   m_per[N_CH];
    int   dly[N_CH];

    always @(posedge clk) begin
        #1;
        if (mon_on) begin
            if (rst) begin
                checks++;
                if (busy !== '0 || done !== '0) begin
                    errors++;
                    $display("FAIL reset_out: busy=%b done=%b, required busy=00 done=00 at %0t", busy, done, $time);
                end
            end else if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_underflow: no expectation queued at %0t", $time);
            end else begin
                e = sb.pop_front();
                checks++;
                if (busy !== e.busy || done !== e.done) begin
                    errors++;
                    $display("FAIL cycle_cmp: busy=%b done=%b, required busy=%b done=%b at %0t",
                             busy, done, e.busy, e.done, $time);
                end
            end
        end
    end

    task automatic step(input logic en, input logic [N_CH-1:0] st, input logic [N_CH-1:0] ab,
                        input logic [N_CH-1:0] pm);
        exp_t x;
        enable   = en;
        start    = st;
        abort    = ab;
        periodic = pm;
        delay_us = {DELAY_W'(dly[1]), DELAY_W'(dly[0])};
        for (int c = 0; c < N_CH; c++) begin
            bit tc;
            bit dn;
            tc = m_run[c] && en && (m_rem[c] == 1);
            dn = 1'b0;
            if (ab[c]) begin
                m_run[c] = 1'b0;
            end else if (st[c]) begin
                dn = tc;
                if (dly[c] != 0) begin
                    m_run[c] = 1'b1;
                    m_rem[c] = dly[c] * FREQ_MHZ;
                    m_per[c] = pm[c];
                end else begin
                    dn       = 1'b1;
                    m_run[c] = 1'b0;
                end
            end else if (m_run[c] && en) begin
                if (m_rem[c] == 1) begin
                    dn = 1'b1;
                    if (m_per[c] && dly[c] != 0) m_rem[c] = dly[c] * FREQ_MHZ;
                    else m_run[c] = 1'b0;
                end else begin
                    m_rem[c] = m_rem[c] - 1;
                end
            end
            x.busy[c] = m_run[c];
            x.done[c] = dn;
        end
        sb.push_back(x);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b1, '0, '0, '0);
    endtask

    task automatic check(input string name, input logic [N_CH-1:0] act, input logic [N_CH-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %b, required %b", name, act, req);
        end
    endtask

    task automatic wait_done(input int ch, input int exp_n, input string name);
        int n;
        n = 0;
        do begin
            step(1'b1, '0, '0, '0);
            n++;
        end while (done[ch] !== 1'b1 && n < 200);
        checks++;
        if (n != exp_n) begin
            errors++;
            $display("FAIL %s: done after %0d cycles, required %0d", name, n, exp_n);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int c = 0; c < N_CH; c++) begin
            m_run[c] = 1'b0;
            m_rem[c] = 0;
            m_per[c] = 1'b0;
            dly[c]   = 0;
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // One-shot, delay 3 us on ch0
        dly[0] = 3;
        step(1'b1, 2'b01, 2'b00, 2'b00);
        check("os_busy", busy, 2'b01);
        wait_done(0, 12, "oneshot");
        check("os_busy_clr", busy, 2'b00);
        idle(3);

        // Periodic on ch1 with live rate change, then stop via zero delay
        dly[1] = 2;
        step(1'b1, 2'b10, 2'b00, 2'b10);
        wait_done(1, 8, "per1");
        wait_done(1, 8, "per2");
        dly[1] = 1;
        wait_done(1, 8, "per3");
        wait_done(1, 4, "per4");
        dly[1] = 0;
        wait_done(1, 4, "per5");
        check("per_idle", busy, 2'b00);
        idle(10);

        // Abort, restart, retrigger
        dly[0] = 5;
        step(1'b1, 2'b01, 2'b00, 2'b00);
        idle(6);
        step(1'b1, 2'b00, 2'b01, 2'b00);
        check("abort_busy", busy, 2'b00);
        check("abort_done", done, 2'b00);
        idle(2);
        dly[0] = 2;
        step(1'b1, 2'b01, 2'b00, 2'b00);
        idle(3);
        dly[0] = 3;
        step(1'b1, 2'b01, 2'b00, 2'b00);
        wait_done(0, 12, "retrig");

        // Abort on the terminal-count edge
        dly[0] = 1;
        step(1'b1, 2'b01, 2'b00, 2'b00);
        idle(3);
        step(1'b1, 2'b00, 2'b01, 2'b00);
        check("abort_tc_done", done, 2'b00);
        idle(4);

        // Zero delay, then enable held low for three cycles mid-run
        dly[0] = 0;
        step(1'b1, 2'b01, 2'b00, 2'b00);
        check("zero_done", done, 2'b01);
        check("zero_busy", busy, 2'b00);
        idle(2);
        dly[0] = 2;
        step(1'b1, 2'b01, 2'b00, 2'b00);
        for (int k = 1; k <= 11; k++) step((k >= 4 && k <= 6) ? 1'b0 : 1'b1, '0, '0, '0);
        check("en_hold_done", done, 2'b01);
        idle(2);

        // Asynchronous reset between edges mid-run
        dly[0] = 3;
        step(1'b1, 2'b01, 2'b00, 2'b00);
        idle(4);
        rst = 1'b1;
        #1;
        check("rst_async_busy", busy, 2'b00);
        check("rst_async_done", done, 2'b00);
        for (int c = 0; c < N_CH; c++) m_run[c] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle(20);
        step(1'b1, 2'b01, 2'b00, 2'b00);
        wait_done(0, 12, "post_rst");

        // Terminal count and restart coincide on ch0 while ch1 runs periodically
        dly[1] = 3;
        step(1'b1, 2'b10, 2'b00, 2'b10);
        dly[0] = 1;
        step(1'b1, 2'b01, 2'b00, 2'b00);
        idle(3);
        step(1'b1, 2'b01, 2'b00, 2'b00);
        check("sim_tc_done", done & 2'b01, 2'b01);
        wait_done(0, 4, "sim_restart");
        idle(10);
        step(1'b1, 2'b00, 2'b10, 2'b00);
        idle(3);

        // Randomized traffic
        repeat (3000) begin
            logic [N_CH-1:0] st;
            logic [N_CH-1:0] ab;
            logic [N_CH-1:0] pm;
            logic            en;
            for (int c = 0; c < N_CH; c++) begin
                if ($urandom_range(0, 15) == 0) dly[c] = $urandom_range(0, 5);
                st[c] = ($urandom_range(0, 11) == 0);
                ab[c] = ($urandom_range(0, 39) == 0);
                pm[c] = $urandom_range(0, 1) == 1;
            end
            en = ($urandom_range(0, 7) != 0);
            step(en, st, ab, pm);
        end
        idle(5);

        mon_on = 1'b0;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: %0d expectations unconsumed, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
